// File: rtl/rv_dmem_resp.sv
// rv_dmem_resp -- data-memory responder for the RV32I MEM stage.
//
// Takes one load/store at a time over a req/ready handshake, waits
// WAIT_CYCLES extra cycles, then does the access. Stores are written with
// byte-lane masking. Loads return sign- or zero-extended data. Every access
// answers with a single-cycle o_dmem_rvalid strobe.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words; the word index is
//                i_dmem_addr[2 +: log2(DEPTH_WORDS)] and upper bits wrap
//   WAIT_CYCLES  extra busy cycles between acceptance and access (0..15)
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_dmem_req       request valid, sampled only while ready
//   i_dmem_we        1 = store, 0 = load
//   i_dmem_addr      byte address
//   i_dmem_wd        store data, lane-0 justified
//   i_dmem_bytectrl  access size/sign (DMEM_BYTECTRL_* encodings)
//   o_dmem_ready     high only in IDLE
//   o_dmem_rvalid    one-cycle response strobe for loads and stores
//   o_dmem_rd        extended load data (0 for stores), held until next access
//   o_dmem_misalign  misaligned-access flag, qualified by o_dmem_rvalid
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned HALF/WORD accesses do not write, loads return 0,
//               and the response carries o_dmem_misalign = 1
//   undefined : o_dmem_misalign is tied to 0. A HALF access uses addr[1] only
//               and a WORD access ignores addr[1:0].
//
// Memory contents are not reset.

`ifndef DMEM_BYTECTRL_BYTE
`define DMEM_BYTECTRL_BYTE  3'b000
`endif
`ifndef DMEM_BYTECTRL_HALF
`define DMEM_BYTECTRL_HALF  3'b001
`endif
`ifndef DMEM_BYTECTRL_WORD
`define DMEM_BYTECTRL_WORD  3'b010
`endif
`ifndef DMEM_BYTECTRL_BYTEU
`define DMEM_BYTECTRL_BYTEU 3'b100
`endif
`ifndef DMEM_BYTECTRL_HALFU
`define DMEM_BYTECTRL_HALFU 3'b101
`endif

module rv_dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dmem_req,
    input  logic        i_dmem_we,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wd,
    input  logic [2:0]  i_dmem_bytectrl,
    output logic        o_dmem_ready,
    output logic        o_dmem_rvalid,
    output logic [31:0] o_dmem_rd,
    output logic        o_dmem_misalign
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  bytectrl;
    } dmem_req_t;

    state_t          state, state_nxt;
    dmem_req_t       req_q;
    logic [3:0]      cnt;
    logic [3:0][7:0] mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0][7:0] rd_word;
    logic [3:0][7:0] wdata;
    logic [3:0]      be;
    logic [7:0]      sel_b;
    logic [15:0]     sel_h;
    logic [31:0]     rd_ext;
    logic            misal;
    logic            access;

    assign idx          = req_q.addr[2 +: AW];
    assign lane         = req_q.addr[1:0];
    assign access       = (state == BUSY) && (cnt == 4'd0);
    assign o_dmem_ready = (state == IDLE);

    // Address bits above the index wrap and are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_q.addr[31:2+AW];

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_dmem_req) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane masks, store-data replication and load extraction.
    always_comb begin
        rd_word = mem[idx];
        sel_b   = rd_word[lane];
        sel_h   = lane[1] ? rd_word[3:2] : rd_word[1:0];
        be      = 4'b1111;
        wdata   = req_q.wd;
        rd_ext  = rd_word;
        misal   = 1'b0;
        case (req_q.bytectrl)
            `DMEM_BYTECTRL_BYTE, `DMEM_BYTECTRL_BYTEU: begin
                be     = 4'b0001 << lane;
                wdata  = {4{req_q.wd[7:0]}};
                rd_ext = (req_q.bytectrl == `DMEM_BYTECTRL_BYTE) ?
                         {{24{sel_b[7]}}, sel_b} : {24'd0, sel_b};
            end
            `DMEM_BYTECTRL_HALF, `DMEM_BYTECTRL_HALFU: begin
                // addr[0] is dropped here; it only matters to the misalign check.
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{req_q.wd[15:0]}};
                rd_ext = (req_q.bytectrl == `DMEM_BYTECTRL_HALF) ?
                         {{16{sel_h[15]}}, sel_h} : {16'd0, sel_h};
`ifdef DMEM_MISALIGN_CHECK_EN
                misal  = lane[0];
`endif
            end
            default: begin
                // Word access: the full word, whatever addr[1:0] is.
`ifdef DMEM_MISALIGN_CHECK_EN
                misal  = (lane != 2'd0);
`endif
            end
        endcase
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q         <= '0;
            cnt           <= 4'd0;
            o_dmem_rvalid <= 1'b0;
            o_dmem_rd     <= 32'd0;
        end else begin
            if (state == IDLE && i_dmem_req) begin
                req_q <= '{we: i_dmem_we, addr: i_dmem_addr,
                           wd: i_dmem_wd, bytectrl: i_dmem_bytectrl};
                cnt   <= 4'(WAIT_CYCLES);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            o_dmem_rvalid <= access;
            if (access)
                o_dmem_rd <= (req_q.we || misal) ? 32'd0 : rd_ext;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misal_q;
    always_ff @(posedge i_clk) begin
        if (i_rst)       misal_q <= 1'b0;
        else if (access) misal_q <= misal;
    end
    assign o_dmem_misalign = misal_q;
`else
    assign o_dmem_misalign = 1'b0;
`endif

    // Storage. It has no reset. A reset in the commit cycle blocks the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && access && req_q.we && !misal) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mem[idx][l] <= wdata[l];
        end
    end

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp. Checks reset state, handshake timing,
// lane masking, load extension, the misalign option, abort by reset,
// held-request throughput and address wrap-around.
module tb_rv_dmem_resp;
    localparam logic [2:0] BC_B  = 3'b000;
    localparam logic [2:0] BC_H  = 3'b001;
    localparam logic [2:0] BC_W  = 3'b010;
    localparam logic [2:0] BC_BU = 3'b100;
    localparam logic [2:0] BC_HU = 3'b101;
    localparam int WAIT = 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic [2:0]  bc = BC_W;
    logic        ready, rvalid, mis;
    logic [31:0] rd;
    logic        req0 = 1'b0;
    logic        ready0, rvalid0, mis0;
    logic [31:0] rd0;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 i_clk = ~i_clk;

    rv_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_dmem_req(req), .i_dmem_we(we),
        .i_dmem_addr(addr), .i_dmem_wd(wd), .i_dmem_bytectrl(bc),
        .o_dmem_ready(ready), .o_dmem_rvalid(rvalid), .o_dmem_rd(rd),
        .o_dmem_misalign(mis)
    );

    // Zero-wait instance used only for the held-request throughput check.
    rv_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_dmem_req(req0), .i_dmem_we(1'b0),
        .i_dmem_addr(32'h0), .i_dmem_wd(32'h0), .i_dmem_bytectrl(BC_W),
        .o_dmem_ready(ready0), .o_dmem_rvalid(rvalid0), .o_dmem_rd(rd0),
        .o_dmem_misalign(mis0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, latency, response value, single pulse.
    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] b,
                        input logic [31:0] exp_rd, input logic exp_mis);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!ready && n < 40) begin @(negedge i_clk); n++; end
        chk({tag, "/ready"}, {31'd0, ready}, 32'd1);
        req = 1'b1; we = w; addr = a; wd = d; bc = b;
        @(negedge i_clk);
        // Scramble inputs: the captured request must be used.
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wd = 32'hA5A5_A5A5; bc = 3'b111;
        chk({tag, "/ready_drop"}, {31'd0, ready}, 32'd0);
        n = 0;
        while (!rvalid && n < 40) begin @(negedge i_clk); n++; end
        chk({tag, "/latency"}, n, WAIT + 1);
        chk({tag, "/rd"}, rd, exp_rd);
        chk({tag, "/misalign"}, {31'd0, mis}, {31'd0, exp_mis});
        @(negedge i_clk);
        chk({tag, "/one_pulse"}, {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [11:0] rp, vp;

        repeat (2) @(negedge i_clk);
        chk("rst/ready", {31'd0, ready}, 32'd1);
        chk("rst/rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst/rd", rd, 32'd0);
        chk("rst/misalign", {31'd0, mis}, 32'd0);
        i_rst = 1'b0;

        xact("sw10",  1'b1, 32'h10, 32'hDEAD_BEEF, BC_W, 32'h0, 1'b0);
        xact("lw10a", 1'b0, 32'h10, 32'h0, BC_W, 32'hDEAD_BEEF, 1'b0);
        xact("sb11",  1'b1, 32'h11, 32'h0000_00AA, BC_B, 32'h0, 1'b0);
        xact("lw10b", 1'b0, 32'h10, 32'h0, BC_W, 32'hDEAD_AAEF, 1'b0);
        xact("lb11",  1'b0, 32'h11, 32'h0, BC_B, 32'hFFFF_FFAA, 1'b0);
        xact("lbu11", 1'b0, 32'h11, 32'h0, BC_BU, 32'h0000_00AA, 1'b0);
        xact("sh12",  1'b1, 32'h12, 32'h0000_8001, BC_H, 32'h0, 1'b0);
        xact("lh12",  1'b0, 32'h12, 32'h0, BC_H, 32'hFFFF_8001, 1'b0);
        xact("lhu12", 1'b0, 32'h12, 32'h0, BC_HU, 32'h0000_8001, 1'b0);
        xact("lw10c", 1'b0, 32'h10, 32'h0, BC_W, 32'h8001_AAEF, 1'b0);
        xact("lb13",  1'b0, 32'h13, 32'h0, BC_B, 32'hFFFF_FF80, 1'b0);
        xact("lbu10", 1'b0, 32'h10, 32'h0, BC_BU, 32'h0000_00EF, 1'b0);
        xact("lh10",  1'b0, 32'h10, 32'h0, BC_H, 32'hFFFF_AAEF, 1'b0);
        // HALFU used for a store behaves as HALF.
        xact("shu16", 1'b1, 32'h16, 32'hFFFF_1234, BC_HU, 32'h0, 1'b0);
        xact("lhu16", 1'b0, 32'h16, 32'h0, BC_HU, 32'h0000_1234, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
        xact("sw13m", 1'b1, 32'h13, 32'h1234_5678, BC_W, 32'h0, 1'b1);
        xact("lw10m", 1'b0, 32'h10, 32'h0, BC_W, 32'h8001_AAEF, 1'b0);
        xact("lh11m", 1'b0, 32'h11, 32'h0, BC_H, 32'h0, 1'b1);
`else
        xact("lw13",  1'b0, 32'h13, 32'h0, BC_W, 32'h8001_AAEF, 1'b0);
        xact("lh11",  1'b0, 32'h11, 32'h0, BC_H, 32'hFFFF_AAEF, 1'b0);
`endif

        // Address wrap-around at DEPTH_WORDS = 1024 (4 KiB).
        xact("lw1010", 1'b0, 32'h1010, 32'h0, BC_W, 32'h8001_AAEF, 1'b0);
        xact("sb1014", 1'b1, 32'h1014, 32'h0000_005A, BC_B, 32'h0, 1'b0);
        xact("lbu14",  1'b0, 32'h14, 32'h0, BC_BU, 32'h0000_005A, 1'b0);

        // Store aborted by reset during BUSY must not commit.
        xact("sw20",  1'b1, 32'h20, 32'h1122_3344, BC_W, 32'h0, 1'b0);
        xact("lw20a", 1'b0, 32'h20, 32'h0, BC_W, 32'h1122_3344, 1'b0);
        @(negedge i_clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h55; bc = BC_W;
        @(negedge i_clk);
        req = 1'b0;
        chk("abort/ready_drop", {31'd0, ready}, 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("abort/ready", {31'd0, ready}, 32'd1);
        chk("abort/rd_cleared", rd, 32'd0);
        n = 0;
        repeat (6) begin
            if (rvalid) n++;
            @(negedge i_clk);
        end
        chk("abort/no_rvalid", n, 0);
        xact("lw20b", 1'b0, 32'h20, 32'h0, BC_W, 32'h1122_3344, 1'b0);

        // Held request on the zero-wait instance: accept every 3rd cycle.
        @(negedge i_clk);
        req0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rp[11-k] = ready0;
            vp[11-k] = rvalid0;
            @(negedge i_clk);
        end
        req0 = 1'b0;
        chk("held/ready", {20'd0, rp}, {20'd0, 12'b1001_0010_0100});
        chk("held/rvalid", {20'd0, vp}, {20'd0, 12'b0010_0100_1001});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
